// File: rtl/usb_auth_responder_pkg.sv
// Shared constants for the USB Type-C authentication responder: message field
// layout, protocol/request/response codes and the responder FSM encoding.
package usb_auth_responder_pkg;

  localparam int MSG_LEN_DEFAULT = 64;

  localparam int VER_LSB  = 0;
  localparam int TYPE_LSB = 8;
  localparam int P1_LSB   = 16;
  localparam int P2_LSB   = 24;
  localparam int PAY_LSB  = 32;

  localparam logic [7:0] PROTO_VER = 8'h01;

  localparam logic [7:0] REQ_GET_DIGESTS     = 8'h81;
  localparam logic [7:0] REQ_GET_CERTIFICATE = 8'h82;
  localparam logic [7:0] REQ_CHALLENGE       = 8'h83;

  localparam logic [7:0] RESP_DIGESTS        = 8'h01;
  localparam logic [7:0] RESP_CERTIFICATE    = 8'h02;
  localparam logic [7:0] RESP_CHALLENGE_AUTH = 8'h03;
  localparam logic [7:0] RESP_ERROR          = 8'h7F;

  localparam logic [7:0] ERR_INVALID_REQUEST = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_MSG,
    ST_PROCESS,
    ST_SEND,
    ST_ERASE
  } auth_state_e;

  typedef enum logic {
    CH_PD,
    CH_DEBUG
  } auth_chan_e;

  function automatic logic is_valid_request(input logic [7:0] code);
    return (code == REQ_GET_DIGESTS) || (code == REQ_GET_CERTIFICATE) ||
           (code == REQ_CHALLENGE);
  endfunction

endpackage

// File: rtl/usb_auth_resp_builder.sv
// Combinational response builder: maps a latched request and the code the
// transport announced onto a DIGESTS / CERTIFICATE / CHALLENGE_AUTH / ERROR message.
module usb_auth_resp_builder
  import usb_auth_responder_pkg::*;
#(
  parameter int          MSG_LEN       = MSG_LEN_DEFAULT,
  parameter logic [31:0] DIGEST_VAL    = 32'h0D16_E57A,
  parameter logic [31:0] CHALLENGE_KEY = 32'hA5C3_5A3C
) (
  input  logic [MSG_LEN-1:0] req_i,
  input  logic [7:0]         exp_code_i,
  output logic [MSG_LEN-1:0] resp_o
);

  logic [7:0]  req_ver;
  logic [7:0]  req_type;
  logic [7:0]  req_p1;
  logic [7:0]  req_p2;
  logic [31:0] req_pay;
  logic        req_ok;

  assign req_ver  = req_i[VER_LSB  +: 8];
  assign req_type = req_i[TYPE_LSB +: 8];
  assign req_p1   = req_i[P1_LSB   +: 8];
  assign req_p2   = req_i[P2_LSB   +: 8];
  assign req_pay  = req_i[PAY_LSB  +: 32];

  assign req_ok = (req_ver == PROTO_VER) && (req_type == exp_code_i) &&
                  is_valid_request(req_type);

  // Start from the error frame; a valid request overwrites the type-specific fields.
  always_comb begin
    resp_o                  = '0;
    resp_o[VER_LSB  +: 8]   = PROTO_VER;
    resp_o[TYPE_LSB +: 8]   = RESP_ERROR;
    resp_o[P1_LSB   +: 8]   = ERR_INVALID_REQUEST;
    if (req_ok) begin
      case (req_type)
        REQ_GET_DIGESTS: begin
          resp_o[TYPE_LSB +: 8]  = RESP_DIGESTS;
          resp_o[P1_LSB   +: 8]  = req_p1;
          resp_o[P2_LSB   +: 8]  = 8'h01;
          resp_o[PAY_LSB  +: 32] = DIGEST_VAL;
        end
        REQ_GET_CERTIFICATE: begin
          resp_o[TYPE_LSB +: 8]  = RESP_CERTIFICATE;
          resp_o[P1_LSB   +: 8]  = req_p1;
          resp_o[P2_LSB   +: 8]  = req_p2;
          resp_o[PAY_LSB  +: 32] = req_pay;
        end
        REQ_CHALLENGE: begin
          resp_o[TYPE_LSB +: 8]  = RESP_CHALLENGE_AUTH;
          resp_o[P1_LSB   +: 8]  = req_p1;
          resp_o[P2_LSB   +: 8]  = 8'h01;
          resp_o[PAY_LSB  +: 32] = req_pay ^ CHALLENGE_KEY;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/usb_auth_responder.sv
// USB Type-C authentication responder serving PD (priority) and DEBUG transports.
// Optional AUTH_ACK_TIMEOUT_EN drops an unacknowledged response after TIMEOUT_CYCLES.
module usb_auth_responder
  import usb_auth_responder_pkg::*;
#(
  parameter int          MSG_LEN        = MSG_LEN_DEFAULT,
  parameter logic [31:0] DIGEST_VAL     = 32'h0D16_E57A,
  parameter logic [31:0] CHALLENGE_KEY  = 32'hA5C3_5A3C,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         pending_auth_request_PD,
  input  logic [7:0]         pending_auth_request_DEBUG,
  input  logic               PD_msg_ready,
  input  logic               DEBUG_msg_ready,
  input  logic [MSG_LEN-1:0] auth_msg_in,
  input  logic               Ack_in,
  output logic [MSG_LEN-1:0] auth_msg_out,
  output logic               auth_msg_ready,
  output logic               PD_out_ready,
  output logic               DEBUG_out_ready,
  output logic               pending_auth_request_PD_erase,
  output logic               pending_auth_request_DEBUG_erase
);

  if (MSG_LEN < 64 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("usb_auth_responder: MSG_LEN must be >= 64 and TIMEOUT_CYCLES >= 1");
  end

  // Handshake: a response is offered while auth_msg_ready is 1 and is consumed
  // on the first rising edge where Ack_in is also 1; Ack_in is ignored otherwise.
  auth_state_e        state_q, state_d;
  auth_chan_e         chan_q, chan_d;
  logic [7:0]         exp_code_q, exp_code_d;
  logic [MSG_LEN-1:0] req_q, req_d;
  logic [MSG_LEN-1:0] msg_out_q, msg_out_d;
  logic               ready_q, ready_d;
  logic               pd_rdy_q, pd_rdy_d;
  logic               dbg_rdy_q, dbg_rdy_d;
  logic               pd_erase_q, pd_erase_d;
  logic               dbg_erase_q, dbg_erase_d;

  logic [MSG_LEN-1:0] resp;
  logic [7:0]         sel_pending;
  logic               sel_msg_ready;
  logic               leave_send;

  usb_auth_resp_builder #(
    .MSG_LEN       (MSG_LEN),
    .DIGEST_VAL    (DIGEST_VAL),
    .CHALLENGE_KEY (CHALLENGE_KEY)
  ) u_builder (
    .req_i      (req_q),
    .exp_code_i (exp_code_q),
    .resp_o     (resp)
  );

  assign sel_pending   = (chan_q == CH_PD) ? pending_auth_request_PD : pending_auth_request_DEBUG;
  assign sel_msg_ready = (chan_q == CH_PD) ? PD_msg_ready : DEBUG_msg_ready;

`ifdef AUTH_ACK_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
  logic             ack_timeout;

  // Counts cycles the response has been visible; the last one is TIMEOUT_CYCLES-1.
  assign ack_timeout = (ack_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign leave_send  = Ack_in | ack_timeout;

  always_comb begin
    ack_cnt_d = '0;
    if (state_q == ST_SEND && ready_q && !leave_send) begin
      ack_cnt_d = ack_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ack_cnt_q <= '0;
    else       ack_cnt_q <= ack_cnt_d;
  end
`else
  assign leave_send = Ack_in;
`endif

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    exp_code_d  = exp_code_q;
    req_d       = req_q;
    msg_out_d   = msg_out_q;
    ready_d     = ready_q;
    pd_erase_d  = 1'b0;
    dbg_erase_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_auth_request_PD != 8'h00) begin
          chan_d     = CH_PD;
          exp_code_d = pending_auth_request_PD;
          state_d    = ST_WAIT_MSG;
        end else if (pending_auth_request_DEBUG != 8'h00) begin
          chan_d     = CH_DEBUG;
          exp_code_d = pending_auth_request_DEBUG;
          state_d    = ST_WAIT_MSG;
        end
      end
      ST_WAIT_MSG: begin
        if (sel_pending == 8'h00) begin
          state_d = ST_IDLE;
        end else if (sel_msg_ready) begin
          req_d   = auth_msg_in;
          state_d = ST_PROCESS;
        end
      end
      ST_PROCESS: begin
        msg_out_d = resp;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        // First SEND cycle raises ready; only a visible offer can be acknowledged.
        if (!ready_q) begin
          ready_d = 1'b1;
        end else if (leave_send) begin
          ready_d     = 1'b0;
          msg_out_d   = '0;
          pd_erase_d  = (chan_q == CH_PD);
          dbg_erase_d = (chan_q == CH_DEBUG);
          state_d     = ST_ERASE;
        end
      end
      ST_ERASE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    pd_rdy_d  = ready_d && (chan_d == CH_PD);
    dbg_rdy_d = ready_d && (chan_d == CH_DEBUG);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      chan_q      <= CH_PD;
      exp_code_q  <= 8'h00;
      req_q       <= '0;
      msg_out_q   <= '0;
      ready_q     <= 1'b0;
      pd_rdy_q    <= 1'b0;
      dbg_rdy_q   <= 1'b0;
      pd_erase_q  <= 1'b0;
      dbg_erase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      exp_code_q  <= exp_code_d;
      req_q       <= req_d;
      msg_out_q   <= msg_out_d;
      ready_q     <= ready_d;
      pd_rdy_q    <= pd_rdy_d;
      dbg_rdy_q   <= dbg_rdy_d;
      pd_erase_q  <= pd_erase_d;
      dbg_erase_q <= dbg_erase_d;
    end
  end

  assign auth_msg_out                     = msg_out_q;
  assign auth_msg_ready                   = ready_q;
  assign PD_out_ready                     = pd_rdy_q;
  assign DEBUG_out_ready                  = dbg_rdy_q;
  assign pending_auth_request_PD_erase    = pd_erase_q;
  assign pending_auth_request_DEBUG_erase = dbg_erase_q;

endmodule

// File: tb/tb_usb_auth_responder.sv
// Self-checking bench for usb_auth_responder: directed scenarios plus randomized
// transactions checked against a field-level reference model of the protocol.
module tb_usb_auth_responder;

  logic        clk;
  logic        reset;
  logic [7:0]  pend_pd;
  logic [7:0]  pend_dbg;
  logic        pd_msg_ready;
  logic        dbg_msg_ready;
  logic [63:0] msg_in;
  logic        ack_in;
  logic [63:0] msg_out;
  logic        msg_ready;
  logic        pd_out_ready;
  logic        dbg_out_ready;
  logic        pd_erase;
  logic        dbg_erase;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 0;
  logic [63:0] exp_q[$];

  usb_auth_responder #(.MSG_LEN(64)) dut (
    .clk                              (clk),
    .reset                            (reset),
    .pending_auth_request_PD          (pend_pd),
    .pending_auth_request_DEBUG       (pend_dbg),
    .PD_msg_ready                     (pd_msg_ready),
    .DEBUG_msg_ready                  (dbg_msg_ready),
    .auth_msg_in                      (msg_in),
    .Ack_in                           (ack_in),
    .auth_msg_out                     (msg_out),
    .auth_msg_ready                   (msg_ready),
    .PD_out_ready                     (pd_out_ready),
    .DEBUG_out_ready                  (dbg_out_ready),
    .pending_auth_request_PD_erase    (pd_erase),
    .pending_auth_request_DEBUG_erase (dbg_erase)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // At most one out_ready and one erase at any time.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check_eq("excl", 64'({pd_out_ready & dbg_out_ready, pd_erase & dbg_erase}), 64'd0);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_resp(input logic [63:0] req, input logic [7:0] code);
    logic [7:0]  f [8];
    logic [31:0] pay;
    logic [63:0] err;
    for (int i = 0; i < 8; i++) f[i] = req[8*i +: 8];
    pay = req[63:32];
    err = {32'h0, 8'h00, 8'h01, 8'h7F, 8'h01};
    if (f[0] != 8'h01 || f[1] != code) return err;
    case (f[1])
      8'h81:   return {32'h0D16E57A, 8'h01, f[2], 8'h01, 8'h01};
      8'h82:   return {pay, f[3], f[2], 8'h02, 8'h01};
      8'h83:   return {pay ^ 32'hA5C35A3C, 8'h01, f[2], 8'h03, 8'h01};
      default: return err;
    endcase
  endfunction

  function automatic logic [7:0] rand_code();
    if ($urandom_range(0, 6) == 0) return 8'($urandom_range(1, 255));
    return 8'($urandom_range(8'h81, 8'h83));
  endfunction

  function automatic logic [63:0] rand_msg(input logic [7:0] code);
    logic [7:0] ver;
    logic [7:0] typ;
    ver = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'h01;
    case ($urandom_range(0, 7))
      0:       typ = 8'($urandom_range(0, 255));
      1:       typ = 8'($urandom_range(8'h81, 8'h83));
      default: typ = code;
    endcase
    return {32'($urandom), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), typ, ver};
  endfunction

  // ---------------- drivers ----------------
  // Called just after a negedge with the wanted pending codes already driven.
  task automatic start_req(input logic [63:0] msg, input logic [63:0] exp, input bit junk,
                           output bit dbg);
    dbg = (pend_pd == 8'h00);
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      ack_in = 1'($urandom_range(0, 1));
    end
    if (junk) begin
      msg_in = {$urandom, $urandom};
      if (dbg) pd_msg_ready = 1'b1;
      else     dbg_msg_ready = 1'b1;
      @(negedge clk);
      pd_msg_ready  = 1'b0;
      dbg_msg_ready = 1'b0;
      check_eq("junk_ignored", 64'(msg_ready), 64'd0);
    end
    ack_in = 1'b0;
    msg_in = msg;
    if (dbg) dbg_msg_ready = 1'b1;
    else     pd_msg_ready  = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    pd_msg_ready  = 1'b0;
    dbg_msg_ready = 1'b0;
    msg_in        = {$urandom, $urandom};
    check_eq("lat_n", 64'(msg_ready), 64'd0);
    @(negedge clk);
    check_eq("lat_n1", 64'(msg_ready), 64'd0);
    @(negedge clk);
    check_eq("lat_n2", 64'(msg_ready), 64'd1);
    check_eq("resp", msg_out, exp_q.pop_front());
    check_eq("out_sel", 64'({pd_out_ready, dbg_out_ready, pd_erase, dbg_erase}),
             dbg ? 64'b0100 : 64'b1000);
  endtask

  task automatic finish_req(input bit dbg, input logic [63:0] exp, input int ack_delay);
    repeat (ack_delay) begin
      @(negedge clk);
      check_eq("hold_rdy", 64'({msg_ready, pd_out_ready, dbg_out_ready}),
               dbg ? 64'b101 : 64'b110);
      check_eq("hold_msg", msg_out, exp);
    end
    ack_in = 1'b1;
    @(negedge clk);
    ack_in = 1'($urandom_range(0, 1));
    check_eq("erase_rdy", 64'({msg_ready, pd_out_ready, dbg_out_ready}), 64'd0);
    check_eq("erase_msg", msg_out, 64'd0);
    check_eq("erase_sel", 64'({pd_erase, dbg_erase}), dbg ? 64'b01 : 64'b10);
    if (dbg) pend_dbg = 8'h00;
    else     pend_pd  = 8'h00;
    @(negedge clk);
    ack_in = 1'b0;
    check_eq("erase_pulse", 64'({pd_erase, dbg_erase}), 64'd0);
  endtask

  task automatic serve(input logic [63:0] msg, input logic [63:0] exp, input bit junk,
                       input int ack_delay);
    bit dbg;
    start_req(msg, exp, junk, dbg);
    finish_req(dbg, exp, ack_delay);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          dbg;
    logic [7:0]  code;
    logic [63:0] m;

    reset         = 1'b1;
    pend_pd       = 8'h00;
    pend_dbg      = 8'h00;
    pd_msg_ready  = 1'b0;
    dbg_msg_ready = 1'b0;
    msg_in        = 64'd0;
    ack_in        = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_flags", 64'({msg_ready, pd_out_ready, dbg_out_ready, pd_erase, dbg_erase}), 64'd0);
    check_eq("rst_msg", msg_out, 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // PD GET_DIGESTS
    pend_pd = 8'h81;
    serve(64'h00000000_00008101, 64'h0D16E57A_01000101, 1'b0, 1);

    // DEBUG CHALLENGE
    pend_dbg = 8'h83;
    serve(64'h12345678_00028301, 64'hB7F70C44_01020301, 1'b1, 0);

    // Both pending: PD certificate first, DEBUG digests after the PD erase
    pend_pd  = 8'h82;
    pend_dbg = 8'h81;
    serve(64'hDEADBEEF_34128201, 64'hDEADBEEF_34120201, 1'b1, 2);
    serve(64'h00000000_00058101, 64'h0D16E57A_01050101, 1'b0, 0);

    // Type mismatch and bad version
    pend_pd = 8'h81;
    serve(64'h00000000_00008301, 64'h00000000_00017F01, 1'b0, 0);
    pend_pd = 8'h82;
    serve(64'h11111111_22338202, 64'h00000000_00017F01, 1'b0, 1);

    // Pending code withdrawn while waiting for the message
    pend_pd = 8'h82;
    repeat (2) @(negedge clk);
    pend_pd = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check_eq("cancel", 64'({msg_ready, pd_out_ready, dbg_out_ready, pd_erase, dbg_erase}), 64'd0);
    end

    // Reset while the response is offered, then the held request restarts
    pend_pd = 8'h81;
    start_req(64'h00000000_00078101, 64'h0D16E57A_01070101, 1'b0, dbg);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_flags", 64'({msg_ready, pd_out_ready, dbg_out_ready, pd_erase, dbg_erase}), 64'd0);
    check_eq("rst_mid_msg", msg_out, 64'd0);
    @(negedge clk);
    check_eq("rst_mid_erase", 64'({pd_erase, dbg_erase}), 64'd0);
    reset = 1'b0;
    serve(64'hCAFEF00D_00098101, 64'h0D16E57A_01090101, 1'b0, 0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0:       pend_pd  = rand_code();
        1:       pend_dbg = rand_code();
        default: begin
          pend_pd  = rand_code();
          pend_dbg = rand_code();
        end
      endcase
      while (pend_pd != 8'h00 || pend_dbg != 8'h00) begin
        code = (pend_pd != 8'h00) ? pend_pd : pend_dbg;
        m    = rand_msg(code);
        serve(m, model_resp(m, code), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
    end

    mon_en = 1'b0;
    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
